demux_stream: RTL and testbench

Parametrised 1-to-CHANNELS registered demultiplexer with valid/ready flow control on the input and on every output channel. Each input word is steered to one channel, either by an explicit `select` or by an internal round-robin pointer, and held in that channel's output register until the consumer takes it. It sits between a single producer and up to CHANNELS independent consumers in the datapath, and generalises the team's 1-to-2 combinational demultiplexer (`d`, `q`, `select`).

---
 rtl/demux_stream.sv | 75 +++++++
 tb/tb_demux_stream.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/demux_stream.sv
// demux_stream: 1-to-CHANNELS registered demultiplexer with valid/ready on the
// input and on every output channel. Target is `select` (mode=0) or an
// internal round-robin pointer (mode=1); each channel holds one word until taken.
module demux_stream #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          d,
    input  logic                      d_valid,
    output logic                      d_ready,
    input  logic [SEL_W-1:0]          select,
    input  logic                      mode,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       q_valid,
    input  logic [CHANNELS-1:0]       q_ready,
    output logic [SEL_W-1:0]          cur_chan
);

    logic [CHANNELS*WIDTH-1:0] q_q,       q_d;
    logic [CHANNELS-1:0]       q_valid_q, q_valid_d;
    logic [SEL_W-1:0]          rr_ptr_q,  rr_ptr_d;

    logic [CHANNELS-1:0]       hit;
    logic [CHANNELS-1:0]       load;
    logic                      accept;

    // Target decode; an out-of-range select matches no channel, so it is never ready.
    always_comb begin
        cur_chan = mode ? rr_ptr_q : select;
        hit      = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (cur_chan == SEL_W'(k)) begin
                hit[k] = 1'b1;
            end
        end
        d_ready = |(hit & (~q_valid_q | q_ready));
        accept  = d_valid & d_ready;
        load    = hit & {CHANNELS{accept}};
    end

    // Next state: load wins over drain on the same channel; pointer moves only on accept.
    always_comb begin
        q_d       = q_q;
        q_valid_d = load | (q_valid_q & ~q_ready);
        rr_ptr_d  = rr_ptr_q;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (load[k]) begin
                q_d[k*WIDTH +: WIDTH] = d;
            end
        end
        if (accept && mode) begin
            rr_ptr_d = (rr_ptr_q == SEL_W'(CHANNELS - 1)) ? '0 : rr_ptr_q + SEL_W'(1);
        end
    end

    // State registers, cleared asynchronously; in-flight words are discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q       <= '0;
            q_valid_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign q       = q_q;
    assign q_valid = q_valid_q;

endmodule

// File: tb/tb_demux_stream.sv
// Testbench for demux_stream: table of directed vectors on a 4-channel instance,
// plus hand-written sequences for mid-stream reset and illegal select (3 channels).
module tb_demux_stream;

    logic clk;
    logic reset;

    // 4-channel instance signals
    logic [7:0]  d4;
    logic        dv4;
    logic        rdy4;
    logic [1:0]  sel4;
    logic        mode4;
    logic [31:0] q4;
    logic [3:0]  qv4;
    logic [3:0]  qr4;
    logic [1:0]  cur4;

    // 3-channel instance signals
    logic [7:0]  d3;
    logic        dv3;
    logic        rdy3;
    logic [1:0]  sel3;
    logic        mode3;
    logic [23:0] q3;
    logic [2:0]  qv3;
    logic [2:0]  qr3;
    logic [1:0]  cur3;

    int n_cmp;
    int n_bad;

    demux_stream #(.WIDTH(8), .CHANNELS(4)) dut4 (
        .clk(clk), .reset(reset), .d(d4), .d_valid(dv4), .d_ready(rdy4),
        .select(sel4), .mode(mode4), .q(q4), .q_valid(qv4), .q_ready(qr4),
        .cur_chan(cur4)
    );

    demux_stream #(.WIDTH(8), .CHANNELS(3)) dut3 (
        .clk(clk), .reset(reset), .d(d3), .d_valid(dv3), .d_ready(rdy3),
        .select(sel3), .mode(mode3), .q(q3), .q_valid(qv3), .q_ready(qr3),
        .cur_chan(cur3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic        dv;
        logic [7:0]  d;
        logic [3:0]  qr;
        logic        rdy;   // expected d_ready before the edge
        logic [1:0]  cur;   // expected cur_chan before the edge
        logic [3:0]  qv;    // expected q_valid after the edge
        logic [31:0] q;     // expected q after the edge
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    function automatic vec_t mk(logic m, logic [1:0] s, logic v, logic [7:0] dd,
                                logic [3:0] r, logic er, logic [1:0] ec,
                                logic [3:0] eqv, logic [31:0] eq);
        vec_t t;
        t.mode = m; t.sel = s; t.dv = v; t.d = dd; t.qr = r;
        t.rdy = er; t.cur = ec; t.qv = eqv; t.q = eq;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive one vector after an edge, check combinational outputs, then registered ones.
    task automatic apply(input vec_t v, input int idx);
        mode4 = v.mode; sel4 = v.sel; dv4 = v.dv; d4 = v.d; qr4 = v.qr;
        #2;
        chk("d_ready", idx, 32'(rdy4), 32'(v.rdy));
        chk("cur_chan", idx, 32'(cur4), 32'(v.cur));
        @(posedge clk); #1;
        chk("q_valid", idx, 32'(qv4), 32'(v.qv));
        chk("q", idx, q4, v.q);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        d4 = '0; dv4 = 0; sel4 = '0; mode4 = 0; qr4 = '0;
        d3 = '0; dv3 = 0; sel3 = '0; mode3 = 0; qr3 = '0;

        //            mode sel dv d      qr       rdy cur qv       q
        vecs[0]  = mk(0, 2, 1, 8'hA5, 4'b0000, 1, 2, 4'b0100, 32'h00A50000);
        vecs[1]  = mk(0, 2, 1, 8'h3C, 4'b0000, 0, 2, 4'b0100, 32'h00A50000);
        vecs[2]  = mk(0, 2, 1, 8'h3C, 4'b0100, 1, 2, 4'b0100, 32'h003C0000);
        vecs[3]  = mk(0, 2, 0, 8'h00, 4'b0100, 1, 2, 4'b0000, 32'h003C0000);
        vecs[4]  = mk(1, 0, 1, 8'h01, 4'b1111, 1, 0, 4'b0001, 32'h003C0001);
        vecs[5]  = mk(1, 0, 1, 8'h02, 4'b1111, 1, 1, 4'b0010, 32'h003C0201);
        vecs[6]  = mk(1, 0, 1, 8'h03, 4'b1111, 1, 2, 4'b0100, 32'h00030201);
        vecs[7]  = mk(1, 0, 1, 8'h04, 4'b1111, 1, 3, 4'b1000, 32'h04030201);
        vecs[8]  = mk(1, 0, 1, 8'h05, 4'b1111, 1, 0, 4'b0001, 32'h04030205);
        vecs[9]  = mk(1, 0, 1, 8'h06, 4'b1111, 1, 1, 4'b0010, 32'h04030605);
        vecs[10] = mk(1, 0, 0, 8'h00, 4'b1111, 1, 2, 4'b0000, 32'h04030605);
        vecs[11] = mk(1, 0, 1, 8'h07, 4'b0000, 1, 2, 4'b0100, 32'h04070605);
        vecs[12] = mk(1, 0, 1, 8'h08, 4'b0000, 1, 3, 4'b1100, 32'h08070605);
        vecs[13] = mk(1, 0, 1, 8'h09, 4'b0000, 1, 0, 4'b1101, 32'h08070609);
        vecs[14] = mk(0, 1, 1, 8'h0A, 4'b0000, 1, 1, 4'b1111, 32'h08070A09);
        vecs[15] = mk(1, 0, 1, 8'h0B, 4'b0000, 0, 1, 4'b1111, 32'h08070A09);
        vecs[16] = mk(1, 0, 1, 8'h0B, 4'b1101, 0, 1, 4'b0010, 32'h08070A09);
        vecs[17] = mk(1, 0, 1, 8'h0B, 4'b0010, 1, 1, 4'b0010, 32'h08070B09);
        vecs[18] = mk(1, 0, 0, 8'h00, 4'b1111, 1, 2, 4'b0000, 32'h08070B09);
        vecs[19] = mk(1, 0, 1, 8'h0C, 4'b1111, 1, 2, 4'b0100, 32'h080C0B09);
        vecs[20] = mk(0, 0, 1, 8'h0D, 4'b1111, 1, 0, 4'b0001, 32'h080C0B0D);
        vecs[21] = mk(0, 0, 1, 8'h0E, 4'b1111, 1, 0, 4'b0001, 32'h080C0B0E);
        vecs[22] = mk(1, 0, 1, 8'h0F, 4'b1111, 1, 3, 4'b1000, 32'h0F0C0B0E);
        vecs[23] = mk(1, 0, 0, 8'h00, 4'b1111, 1, 0, 4'b0000, 32'h0F0C0B0E);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_q_valid", 0, 32'(qv4), 32'h0);
        chk("rst_q", 0, q4, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i], i);
        end

        // Mid-stream reset with channels 0 and 2 full
        mode4 = 0; sel4 = 2'd0; dv4 = 1; d4 = 8'h11; qr4 = 4'b0000;
        @(posedge clk); #1;
        sel4 = 2'd2; d4 = 8'h22;
        @(posedge clk); #1;
        chk("pre_rst_q_valid", 0, 32'(qv4), 32'h5);
        mode4 = 1; d4 = 8'h33;
        #2 reset = 1'b1;
        #1;
        chk("midrst_q_valid", 0, 32'(qv4), 32'h0);
        chk("midrst_q", 0, q4, 32'h0);
        chk("midrst_cur_chan", 0, 32'(cur4), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        d4 = 8'h55;
        #1;
        chk("postrst_d_ready", 0, 32'(rdy4), 32'h1);
        @(posedge clk); #1;
        chk("postrst_q_valid", 0, 32'(qv4), 32'h1);
        chk("postrst_q", 0, q4, 32'h00000055);
        chk("postrst_cur_chan", 0, 32'(cur4), 32'h1);
        dv4 = 0;

        // Illegal select on the 3-channel instance
        mode3 = 0; sel3 = 2'd1; dv3 = 1; d3 = 8'h77; qr3 = 3'b000;
        @(posedge clk); #1;
        chk("ill_load_q_valid", 0, 32'(qv3), 32'h2);
        sel3 = 2'd3; d3 = 8'h99;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("ill_d_ready", c, 32'(rdy3), 32'h0);
            @(posedge clk); #1;
            chk("ill_q_valid", c, 32'(qv3), 32'h2);
            chk("ill_q", c, 32'(q3), 32'h007700);
        end
        dv3 = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
